// File: rtl/dmux16_stream.sv
// Purpose: routes one source word per accepted cycle to one of N channels, or to all of them (broadcast).
// Latency: 1 cycle from accept to out_valid/out_data of the target channel(s).
// Backpressure: in_ready drops unless every target is free; broadcast is all-or-nothing; stalls are counted.
module dmux16_stream #(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SELW-1:0]    in_sel,
  input  logic               in_bcast,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [N*WIDTH-1:0] out_data,
  output logic [N-1:0]       out_valid,
  input  logic [N-1:0]       out_ready,
  output logic [15:0]        stall_cnt
);

  // Per-channel holding registers and full flags.
  logic [N-1:0][WIDTH-1:0] r_data;
  logic [N-1:0]            r_valid;
  logic [15:0]             r_stall;

  // A channel is free when it is empty or its sink is taking the word this cycle.
  logic [N-1:0] w_free;
  logic [N-1:0] w_target;
  logic         w_ready;
  logic         w_accept;
  logic         w_stall;

  assign w_free = ~r_valid | out_ready;

  // Target mask: every channel on broadcast, otherwise the one selected.
  always_comb begin
    w_target = '0;
    for (int k = 0; k < N; k++) begin
      w_target[k] = in_bcast || (in_sel == SELW'(k));
    end
  end

  // Ready depends only on select, broadcast and sink readiness (never on in_valid),
  // so the source may look at it before offering a word. Held low during reset.
  always_comb begin
    w_ready = 1'b0;
    if (!reset) begin
      if (in_bcast) begin
        w_ready = &w_free;
      end else begin
        w_ready = w_free[in_sel];
      end
    end
  end

  assign w_accept = in_valid & w_ready;
  assign w_stall  = in_valid & ~w_ready;

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_chan
      // Load beats drain so a draining channel takes the next word without a bubble.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_valid[g] <= 1'b0;
          r_data[g]  <= '0;
        end else if (w_accept && w_target[g]) begin
          r_valid[g] <= 1'b1;
          r_data[g]  <= in_data;
        end else if (out_ready[g]) begin
          r_valid[g] <= 1'b0;
        end
      end
    end
  endgenerate

  // Saturating count of cycles where a word was offered but refused.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall <= '0;
    end else if (w_stall && (r_stall != 16'hFFFF)) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign in_ready  = w_ready;
  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign stall_cnt = r_stall;

endmodule

// File: tb/tb_dmux16_stream.sv
// Directed bench for dmux16_stream (N=4, WIDTH=16).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// Each scenario task checks its own expectations inline.
module tb_dmux16_stream;

  logic        clk;
  logic        reset;
  logic [15:0] in_data;
  logic [1:0]  in_sel;
  logic        in_bcast;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [15:0] stall_cnt;

  int checks;
  int failures;

  dmux16_stream #(.WIDTH(16), .N(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_bcast  (in_bcast),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_sel = 2'd0; in_bcast = 1'b0;
    in_data = 16'h5555; out_ready = 4'b0000;
    step(); step();
    checks++;
    if (out_valid !== 4'b0000) begin failures++; $display("FAIL reset_valid got=%b exp=%b", out_valid, 4'b0000); end
    checks++;
    if (out_data !== 64'h0) begin failures++; $display("FAIL reset_data got=%h exp=%h", out_data, 64'h0); end
    checks++;
    if (stall_cnt !== 16'h0) begin failures++; $display("FAIL reset_stall got=%h exp=%h", stall_cnt, 16'h0); end
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_inready got=%b exp=0", in_ready); end
    reset = 1'b0; in_valid = 1'b0;
    step();
    checks++;
    if (stall_cnt !== 16'h0) begin failures++; $display("FAIL reset_nocount got=%h exp=%h", stall_cnt, 16'h0); end
  endtask

  task automatic test_unicast();
    in_sel = 2'd2; in_data = 16'hBEEF; in_valid = 1'b1; out_ready = 4'b0000;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL uni_inready got=%b exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 4'b0100) begin failures++; $display("FAIL uni_valid got=%b exp=%b", out_valid, 4'b0100); end
    checks++;
    if (out_data !== 64'h0000_BEEF_0000_0000) begin failures++; $display("FAIL uni_data got=%h exp=%h", out_data, 64'h0000_BEEF_0000_0000); end
  endtask

  task automatic test_backpressure();
    in_sel = 2'd2; in_data = 16'hCAFE; in_valid = 1'b1; out_ready = 4'b0000;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_inready_low got=%b exp=0", in_ready); end
    step(); step(); step();
    checks++;
    if (stall_cnt !== 16'd3) begin failures++; $display("FAIL bp_stall got=%0d exp=3", stall_cnt); end
    checks++;
    if (out_data[47:32] !== 16'hBEEF) begin failures++; $display("FAIL bp_hold got=%h exp=%h", out_data[47:32], 16'hBEEF); end
    out_ready = 4'b0100;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_inready_high got=%b exp=1", in_ready); end
    step();
    in_valid = 1'b0; out_ready = 4'b0000;
    checks++;
    if (out_valid !== 4'b0100) begin failures++; $display("FAIL bp_valid got=%b exp=%b", out_valid, 4'b0100); end
    checks++;
    if (out_data[47:32] !== 16'hCAFE) begin failures++; $display("FAIL bp_newdata got=%h exp=%h", out_data[47:32], 16'hCAFE); end
    checks++;
    if (stall_cnt !== 16'd3) begin failures++; $display("FAIL bp_stall_after got=%0d exp=3", stall_cnt); end
  endtask

  task automatic test_broadcast();
    // Load channel 1 while draining channel 2: leaves only channel 1 full.
    in_sel = 2'd1; in_data = 16'h1111; in_valid = 1'b1; out_ready = 4'b0100;
    step();
    in_valid = 1'b0; out_ready = 4'b0000;
    checks++;
    if (out_valid !== 4'b0010) begin failures++; $display("FAIL bc_setup got=%b exp=%b", out_valid, 4'b0010); end
    in_bcast = 1'b1; in_data = 16'h1234; in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL bc_blocked got=%b exp=0", in_ready); end
    step();
    checks++;
    if (out_valid !== 4'b0010) begin failures++; $display("FAIL bc_nowrite_valid got=%b exp=%b", out_valid, 4'b0010); end
    checks++;
    if (out_data !== 64'h0000_CAFE_1111_0000) begin failures++; $display("FAIL bc_nowrite_data got=%h exp=%h", out_data, 64'h0000_CAFE_1111_0000); end
    checks++;
    if (stall_cnt !== 16'd4) begin failures++; $display("FAIL bc_stall got=%0d exp=4", stall_cnt); end
    out_ready = 4'b0010;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL bc_release got=%b exp=1", in_ready); end
    step();
    in_valid = 1'b0; in_bcast = 1'b0; out_ready = 4'b0000;
    checks++;
    if (out_valid !== 4'b1111) begin failures++; $display("FAIL bc_valid got=%b exp=%b", out_valid, 4'b1111); end
    checks++;
    if (out_data !== 64'h1234_1234_1234_1234) begin failures++; $display("FAIL bc_data got=%h exp=%h", out_data, 64'h1234_1234_1234_1234); end
  endtask

  task automatic test_back_to_back();
    out_ready = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      in_sel = 2'd0; in_data = 16'(i); in_valid = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_inready[%0d] got=%b exp=1", i, in_ready); end
      @(posedge clk); #1;
      checks++;
      if (out_valid[0] !== 1'b1 || out_data[15:0] !== 16'(i)) begin
        failures++;
        $display("FAIL stream_word[%0d] got valid=%b data=%h exp valid=1 data=%h", i, out_valid[0], out_data[15:0], 16'(i));
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 4'b1110) begin failures++; $display("FAIL stream_drain got=%b exp=%b", out_valid, 4'b1110); end
    out_ready = 4'b0000;
  endtask

  task automatic test_reset_mid();
    // Drain channels 1 and 2 while loading channel 0: channels 0 and 3 stay full.
    in_sel = 2'd0; in_data = 16'hAAAA; in_valid = 1'b1; out_ready = 4'b0110;
    step();
    out_ready = 4'b0000; in_sel = 2'd3; in_data = 16'h3333;
    step();
    checks++;
    if (out_valid !== 4'b1001 || stall_cnt !== 16'd5) begin
      failures++;
      $display("FAIL rstmid_setup got valid=%b stall=%0d exp valid=1001 stall=5", out_valid, stall_cnt);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL rstmid_inready got=%b exp=0", in_ready); end
    step();
    checks++;
    if (out_valid !== 4'b0000 || out_data !== 64'h0 || stall_cnt !== 16'h0) begin
      failures++;
      $display("FAIL rstmid_state got valid=%b data=%h stall=%h exp 0/0/0", out_valid, out_data, stall_cnt);
    end
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL rstmid_inready_held got=%b exp=0", in_ready); end
    reset = 1'b0; in_valid = 1'b0;
    step();
  endtask

  task automatic test_saturation();
    in_sel = 2'd0; in_data = 16'h0F0F; in_valid = 1'b1; out_ready = 4'b0000;
    step();
    checks++;
    if (out_valid !== 4'b0001 || stall_cnt !== 16'h0) begin
      failures++;
      $display("FAIL sat_setup got valid=%b stall=%h exp valid=0001 stall=0", out_valid, stall_cnt);
    end
    repeat (65534) @(posedge clk);
    #1;
    checks++;
    if (stall_cnt !== 16'hFFFE) begin failures++; $display("FAIL sat_near got=%h exp=%h", stall_cnt, 16'hFFFE); end
    step();
    checks++;
    if (stall_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_reach got=%h exp=%h", stall_cnt, 16'hFFFF); end
    repeat (4465) @(posedge clk);
    #1;
    checks++;
    if (stall_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%h exp=%h", stall_cnt, 16'hFFFF); end
    in_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_unicast();
    test_backpressure();
    test_broadcast();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmux16_stream.md
# dmux16_stream

Registered 16-bit stream demultiplexer: the write-side counterpart of the 16-bit word multiplexers. It takes one word per accepted cycle from a single source and delivers it to one of N sink channels, or to all channels at once in broadcast mode. Each channel has its own one-entry holding register with valid/ready flow control. It sits between the Hack datapath's result bus and downstream consumers such as memory-mapped output registers and peripheral ports.

## Interface
Parameters:
- WIDTH, 16, data word width per channel.
- N, 4, number of output channels; a power of two, 2..16.
- SELW, $clog2(N), width of the channel select.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  word to deliver.
- in_sel  input  SELW  destination channel index; ignored when in_bcast=1.
- in_bcast  input  1  deliver in_data to every channel.
- in_valid  input  1  source offers a word this cycle.
- in_ready  output  1  block accepts the word this cycle (combinational).
- out_data  output  N*WIDTH  channel k data in bits [k*WIDTH +: WIDTH]; registered.
- out_valid  output  N  channel k holds an undelivered word; registered.
- out_ready  input  N  sink k takes the word this cycle.
- stall_cnt  output  16  count of cycles with in_valid=1 and in_ready=0; saturating.

## Operation
- Channel k is "free" when out_valid[k]=0 or out_ready[k]=1.
- Unicast (in_bcast=0): in_ready = free[in_sel].
- Broadcast (in_bcast=1): in_ready = AND over all free[k]. There is no partial delivery; a broadcast is accepted by all channels in the same cycle or by none.
- Accept = in_valid & in_ready. On accept, every target channel loads out_data[k] <= in_data and sets out_valid[k] <= 1.
- A non-targeted channel with out_valid=1 and out_ready=1 clears out_valid. Its out_data holds its last value.
- A targeted channel that is draining in the same cycle (out_valid=1, out_ready=1, accept) keeps out_valid=1 and takes the new word. There is no bubble.
- out_data of a channel changes only on a load.
- The source must hold in_data, in_sel and in_bcast stable while in_valid=1 and in_ready=0. The block does not check this.
- stall_cnt increments by 1 in every cycle with in_valid=1 and in_ready=0. It saturates at 16'hFFFF and never wraps.
- in_ready is valid even when in_valid=0, so the source may sample it early.
- There is no internal FSM beyond the per-channel valid flags. Each channel is independently EMPTY (out_valid=0) or FULL (out_valid=1):
  - EMPTY->FULL on load.
  - FULL->EMPTY on drain without load.
  - FULL->FULL on load, or on no drain.

## Timing
- Latency: a word accepted at edge t appears on out_data/out_valid of its target channel(s) after edge t, i.e. 1 cycle.
- Throughput: 1 word/cycle per channel when the sink holds out_ready=1 continuously. Aggregate throughput is 1 word/cycle.
- Combinational paths: in_sel, in_bcast and out_ready to in_ready. No path from in_valid to in_ready.
- Reset, sampled on a clk edge with reset=1:
  - out_valid=0, out_data=0, stall_cnt=0.
  - Any word pending in a channel is discarded.
  - While reset=1, in_ready is forced to 0 and no accept occurs. Counting resumes the cycle after reset deasserts.
- Reset in the middle of a stalled transfer drops the stall. The source must re-present its word after reset.
- Simultaneous events:
  - Load and drain on the same channel: load wins (stays FULL, new data).
  - Broadcast while one channel is FULL and not ready: in_ready=0 and stall_cnt counts. Free channels are still not written.

## Test plan
- Unicast: after reset, in_sel=2, in_data=16'hBEEF, in_valid=1, all out_ready=0 -> in_ready=1. Next cycle out_valid=4'b0100 and channel 2 data=16'hBEEF; channels 0/1/3 data=0.
- Backpressure: channel 2 FULL with out_ready[2]=0, then offer in_sel=2 for 3 cycles -> in_ready=0 and stall_cnt=3. Raise out_ready[2] -> accept that cycle, and the new word replaces the old one with out_valid[2] held at 1.
- Broadcast: offer in_bcast=1, in_data=16'h1234 with channel 1 FULL and not ready -> no channel written. Release out_ready[1] -> all four channels load 16'h1234 and out_valid=4'b1111.
- Streaming: out_ready[0]=1 held, 8 consecutive words 0..7 to channel 0 -> in_ready=1 every cycle and the sink sees 0..7 in order with no bubbles.
- Saturation: hold a blocked in_valid for 70000 cycles -> stall_cnt=16'hFFFF and it stays there.
- Reset mid-operation: channels 0 and 3 FULL with stall_cnt=5, then assert reset for 1 cycle -> out_valid=0, out_data=0, stall_cnt=0, and in_ready=0 during reset.
